// File: rtl/data_request_arbiter.sv
// Round-robin arbiter for NCH data-request channels onto one memory port.
// It gates instruction fetch around data accesses and latches halt stickily.
module data_request_arbiter #(
    parameter int NCH  = 2,
    parameter int CNTW = 8
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            halt,
    input  logic [NCH-1:0]  r_req,
    input  logic [NCH-1:0]  w_req,
    input  logic            iHit,
    input  logic            dHit,
    output logic            iRen,
    output logic            dRen,
    output logic            dWen,
    output logic [NCH-1:0]  gnt,
    output logic [NCH-1:0]  done,
    output logic            halted,
    output logic [CNTW-1:0] stall_cnt
);

    localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DREAD  = 2'd1,
        DWRITE = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [NCH-1:0]  r_gnt;
    logic [LW-1:0]   r_last;
    logic            r_halted;
    logic [CNTW-1:0] r_stall_cnt;

    logic [NCH-1:0]  w_pending;
    logic            w_found;
    logic [LW-1:0]   w_winner;
    logic            w_winner_write;
    logic            w_in_data;
    logic            w_accept;

    assign w_pending      = r_req | w_req;
    assign w_winner_write = w_req[w_winner];
    assign w_in_data      = (r_state == DREAD) || (r_state == DWRITE);
    // Requests are only taken at an instruction boundary, or any cycle once parked.
    assign w_accept       = w_found && (((r_state == FETCH) && iHit) || (r_state == HALTED));

    // Scan starts one past the previous owner so every pending channel gets a turn.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = int'(r_last) + i;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!w_found && w_pending[idx]) begin
                w_found  = 1'b1;
                w_winner = LW'(idx);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            FETCH: begin
                if (w_accept) begin
                    w_next_state = w_winner_write ? DWRITE : DREAD;
                end else if (halt) begin
                    w_next_state = HALTED;
                end
            end
            DREAD, DWRITE: begin
                if (dHit) begin
                    w_next_state = (r_halted || halt) ? HALTED : FETCH;
                end
            end
            HALTED: begin
                if (w_accept) begin
                    w_next_state = w_winner_write ? DWRITE : DREAD;
                end
            end
            default: w_next_state = FETCH;
        endcase
    end

    always_comb begin
        iRen = (r_state == FETCH) && !halt;
        dRen = (r_state == DREAD);
        dWen = (r_state == DWRITE);
        done = {NCH{dHit && w_in_data}} & r_gnt;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_gnt       <= '0;
            r_last      <= LW'(NCH - 1);
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_halted <= r_halted || halt;
            if (w_accept) begin
                r_gnt       <= NCH'(1) << w_winner;
                r_last      <= w_winner;
                r_stall_cnt <= '0;
            end else if (w_in_data) begin
                if (dHit) begin
                    r_gnt <= '0;
                end else if (r_stall_cnt != '1) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign halted    = r_halted;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/data_request_arbiter.md
# data_request_arbiter

Parametrised successor to the single-channel request unit. It arbitrates `NCH` independent data-request channels onto one memory port, round-robin. It gates instruction fetch around data accesses, latches `halt` stickily, and reports per-channel completion and per-access wait cycles. It sits between the datapath's memory-stage requesters (e.g. load/store unit, future debug port) and the memory controller's `iRen`/`dRen`/`dWen` interface.

## Interface
- `NCH`, default 2: number of data-request channels (≥1).
- `CNTW`, default 8: width of the wait-cycle counter.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `nRST`  in  1  reset, synchronous, active-low.
- `halt`  in  1  processor halt request.
- `r_req`  in  `NCH`  per-channel data read request; level, held until `done`.
- `w_req`  in  `NCH`  per-channel data write request; level, held until `done`.
- `iHit`  in  1  memory controller: instruction fetch complete this cycle.
- `dHit`  in  1  memory controller: data access complete this cycle.
- `iRen`  out  1  instruction read enable.
- `dRen`  out  1  data read enable.
- `dWen`  out  1  data write enable.
- `gnt`  out  `NCH`  one-hot owner of the current data access; 0 when none.
- `done`  out  `NCH`  one-cycle completion strobe to the granted channel.
- `halted`  out  1  sticky halt status.
- `stall_cnt`  out  `CNTW`  wait cycles of the current or last data access, saturating.

## Operation
- **States:** FETCH, DREAD, DWRITE, HALTED. Registers: `state`, `gnt`, `last` (index of the last granted channel), `halted`, `stall_cnt`.
- **Reset** (`nRST`=0 at a rising edge):
  - state=FETCH, gnt=0, last=`NCH`-1 (channel 0 wins first), halted=0, stall_cnt=0.
  - Reset mid-access abandons the access. No `done` is issued.
- **Output decode, combinational from registered state:**
  - `iRen` = (state==FETCH) & ~`halt`.
  - `dRen` = (state==DREAD).
  - `dWen` = (state==DWRITE).
  - `dRen` and `dWen` are never both 1. `iRen` is 0 whenever `dRen` or `dWen` is 1.
- **Acceptance condition:** a data request is accepted in FETCH only when `iHit`=1 (instruction boundary), or in HALTED in any cycle.
- **Arbitration:**
  - Channel k is pending when `r_req`[k] | `w_req`[k].
  - Scan from `last`+1 upward, wrapping modulo `NCH`. The first pending channel wins.
  - Write has priority over read on the same channel: if both are set, go to DWRITE.
  - On accept: `gnt` ← one-hot(winner), `last` ← winner, stall_cnt ← 0.
- **Data states:**
  - While `dHit`=0: stay, and stall_cnt increments, saturating at 2^`CNTW`-1.
  - On `dHit`=1: `done`[winner]=1 this cycle (`done` = {`NCH`{`dHit` & (state==DREAD|DWRITE)}} & `gnt`). Next state is HALTED if `halted` is set, else FETCH. `gnt` ← 0. stall_cnt holds its final value.
- **Halt:**
  - `halt`=1 in FETCH with no accept that cycle: next state HALTED and halted←1.
  - `halt`=1 in a data state: halted←1; the access completes first, then the next state is HALTED.
  - HALTED still serves data requests and returns to HALTED. Only reset leaves it.
- **Simultaneous `halt` and accept in FETCH:** the accept wins and halted←1.
- **Protocol contract:** a requester must drop its request in the cycle after `done`. A request still held then is treated as new and competes round-robin. `dHit` outside a data state is ignored.

## Timing
- Request accepted at edge N (`iHit`=1, request high) → `dRen`/`dWen` and `gnt` valid from cycle N+1.
- `dHit` in cycle M → `done` in cycle M (combinational). `dRen`/`dWen`/`gnt` low and `iRen` high (unless halted) from M+1.
- Minimum data access: 1 cycle (`dHit` in the first data cycle, stall_cnt=0).
- `halt` drops `iRen` in the same cycle (combinational).
- `halted` rises at the edge after `halt` is sampled.

## Test plan
- **Reset:** hold `nRST`=0 for 2 edges with r_req=0b11 → gnt=0, halted=0, stall_cnt=0, `dRen`=`dWen`=0, `iRen`=1. Release reset → `iRen`=1 next cycle.
- **Single read with wait:** r_req[0]=1, `iHit`=1 one cycle → `dRen`=1, gnt=0b01, `iRen`=0 next cycle. Then `dHit`=0 for 3 cycles → stall_cnt=3. Then `dHit`=1 → done=0b01 same cycle; next cycle `dRen`=0, `iRen`=1, stall_cnt stays 3.
- **Round-robin and write priority:**
  - r_req=0b11 held across accesses → grants alternate 0b01, 0b10, 0b01.
  - With `w_req`[1]=1 and `r_req`[1]=1 while channel 1 wins → `dWen`=1, `dRen`=0.
- **Instruction boundary:** r_req[0]=1 with `iHit`=0 for 5 cycles → stays in FETCH (`dRen`=0). Assert `iHit` → `dRen`=1 next cycle.
- **Halt during an access:** `halt`=1 while `dWen`=1 and `dHit`=0 → halted=1 next edge, `dWen` stays 1. After `dHit` → `iRen`=0 permanently. A later r_req[1]=1 is still served with `iHit`=0 and returns to HALTED.
- **Saturation and reset mid-access:**
  - With `CNTW`=2, hold `dHit`=0 for 6 cycles → stall_cnt=3.
  - Assert `nRST`=0 mid-access → next cycle FETCH, gnt=0, no `done` pulse.
